dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
- Upstream control stage for the DSP48A1 slice.
- Accepts a stream of (A, B) operand pairs over valid/ready and drives the slice's A, B, OPMODE and CE inputs so that it computes an N_TAPS-term signed dot product, using multiply-accumulate with P feedback.
- Waits out the slice pipeline, captures P, and presents the 48-bit result on a valid/ready output.
- Used as the front end of FIR/MAC datapaths built on the slice.

Parameters:
- N_TAPS, 8: terms per frame, legal range 1..4096.
- PIPE_LAT, 3: edges from operands appearing on DSP_A/DSP_B to the P register holding their contribution. Matches A1REG=1, MREG=1, PREG=1. Legal range 1..7.
- OPMODE_SKEW, 1: edges DSP_OPMODE lags the operands it belongs to. Range 0..3.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- S_VALID  in  1  operand pair valid.
- S_READY  out  1  sequencer accepts operand pair.
- S_A  in  18  signed multiplicand.
- S_B  in  18  signed multiplier.
- M_VALID  out  1  result valid.
- M_READY  in  1  downstream accepts result.
- M_RESULT  out  48  signed dot product.
- DSP_A  out  18  to slice A.
- DSP_B  out  18  to slice B (B_INPUT="DIRECT").
- DSP_OPMODE  out  8  to slice OPMODE.
- DSP_CE  out  1  drives all slice CE* inputs.
- DSP_P  in  48  from slice P.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, all counters 0, OPMODE skew pipe cleared. Outputs while in reset: DSP_A=0, DSP_B=0, DSP_OPMODE=0, DSP_CE=0, S_READY=0, M_VALID=0, M_RESULT=0, BUSY=0.
- DSP_CE is 1 from the first edge after reset release and stays 1. The slice pipeline always advances; there is no stall.
- Accept: a beat is accepted on an edge where S_VALID & S_READY. The accepting edge loads DSP_A=S_A and DSP_B=S_B.
- Issued-term opcodes, aligned via the skew pipe:
  - OP_FIRST=8'b0000_0001 (X=M, Z=0).
  - OP_ACC=8'b0000_1001 (X=M, Z=P).
  - OP_ZERO=8'h00.
  - Pre-adder, carry and post-subtract bits are always 0.
- Bubble: on any edge in ACCUM or DRAIN with no accepted beat, DSP_A=DSP_B=0 with OP_ACC, so the slice accumulates 0.
- States:
  - IDLE: S_READY=1. No accept: zeros with OP_ZERO. Accept: term 0 with OP_FIRST, tap_cnt=1, go to ACCUM; if N_TAPS=1, go to DRAIN instead.
  - ACCUM: S_READY=1. Each accept issues the term with OP_ACC and increments tap_cnt. The accept that makes tap_cnt=N_TAPS moves to DRAIN with drain_cnt=0.
  - DRAIN: S_READY=0. Issues bubbles and increments drain_cnt each edge. At the edge where drain_cnt=PIPE_LAT, M_RESULT<=DSP_P, M_VALID<=1, go to HOLD. This puts M_VALID high PIPE_LAT+1 edges after the last accept.
  - HOLD: S_READY=0, bubbles continue. M_RESULT and M_VALID stay stable until M_VALID & M_READY; that edge clears M_VALID and returns to IDLE. The next frame may be accepted on the following edge.
- Arithmetic: 18x18 signed product, sign-extended into the 48-bit accumulator. N_TAPS≤4096 cannot overflow, so there is no overflow flag.
- Reset mid-frame: the partial sum is discarded. The first post-reset frame must begin with OP_FIRST.
- The skew pipe must carry OP_FIRST with its own operand, not with a bubble.

Test Plan:
- Bench instantiates the slice with A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, and uses N_TAPS=4, PIPE_LAT=3, OPMODE_SKEW=1.
- Basic: beats (2,5),(3,4),(1,1),(6,7) back-to-back with M_READY=1 → M_RESULT=48'd65, M_VALID for exactly 1 cycle, 4 edges after the last accept.
- Bubbles: same beats with S_VALID low for 2 cycles between each beat → M_RESULT=65, BUSY high throughout.
- Signed: beats (18'h3FFFD,5),(1,1),(0,0),(0,0) → M_RESULT=48'hFFFF_FFFF_FFF2 (-14).
- Backpressure: M_READY low for 5 cycles after M_VALID → M_RESULT held at 65, S_READY=0. Release M_READY, then run a second frame (1,1)x4 → M_RESULT=4, with no carry-over from the previous frame.
- Reset mid-frame: pull RST_N low after 2 accepted beats → all outputs 0 immediately. Release, then send the basic frame → M_RESULT=65.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Control front end for a DSP48A1 slice. Streams (A, B) operand pairs into the
// slice as an N_TAPS-term multiply-accumulate, waits out the slice pipeline,
// then captures P and offers it on a valid/ready result port.
module dsp_mac_sequencer #(
  parameter int unsigned N_TAPS      = 8,
  parameter int unsigned PIPE_LAT    = 3,
  parameter int unsigned OPMODE_SKEW = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic [17:0] S_A,
  input  logic [17:0] S_B,
  output logic        M_VALID,
  input  logic        M_READY,
  output logic [47:0] M_RESULT,
  output logic [17:0] DSP_A,
  output logic [17:0] DSP_B,
  output logic [7:0]  DSP_OPMODE,
  output logic        DSP_CE,
  input  logic [47:0] DSP_P,
  output logic        BUSY
);

  localparam int unsigned TapW = (N_TAPS > 1) ? $clog2(N_TAPS + 1) : 1;
  localparam logic [TapW-1:0] TapLast = TapW'(N_TAPS - 1);
  localparam logic [2:0] DrainLast = 3'(PIPE_LAT);

  // X=M, Z=0 starts a sum; X=M, Z=P accumulates; all-zero flushes the slice.
  localparam logic [7:0] OpFirst = 8'b0000_0001;
  localparam logic [7:0] OpAcc   = 8'b0000_1001;
  localparam logic [7:0] OpZero  = 8'h00;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StHold} state_e;

  state_e            state_q, state_d;
  logic [TapW-1:0]   tap_cnt_q, tap_cnt_d;
  logic [2:0]        drain_cnt_q, drain_cnt_d;
  logic [17:0]       a_q, a_d, b_q, b_d;
  logic [7:0]        op_d;
  logic [OPMODE_SKEW:0][7:0] op_pipe_q, op_pipe_d;
  logic              ce_q;
  logic              m_valid_q, m_valid_d;
  logic [47:0]       m_result_q, m_result_d;
  logic              accept;

  // ce_q gates S_READY so nothing is accepted before the slice is enabled.
  assign S_READY    = ce_q & ((state_q == StIdle) | (state_q == StAccum));
  assign accept     = S_VALID & S_READY;
  assign BUSY       = (state_q != StIdle);
  assign DSP_A      = a_q;
  assign DSP_B      = b_q;
  assign DSP_OPMODE = op_pipe_q[OPMODE_SKEW];
  assign DSP_CE     = ce_q;
  assign M_VALID    = m_valid_q;
  assign M_RESULT   = m_result_q;

  // Next-state, operand and opcode selection for the issued term.
  always_comb begin
    state_d     = state_q;
    tap_cnt_d   = tap_cnt_q;
    drain_cnt_d = drain_cnt_q;
    m_valid_d   = m_valid_q;
    m_result_d  = m_result_q;
    a_d         = '0;
    b_d         = '0;
    op_d        = OpZero;
    if (accept) begin
      a_d = S_A;
      b_d = S_B;
    end
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d        = OpFirst;
          tap_cnt_d   = TapW'(1);
          drain_cnt_d = '0;
          state_d     = (N_TAPS == 1) ? StDrain : StAccum;
        end
      end
      StAccum: begin
        op_d = OpAcc;
        if (accept) begin
          tap_cnt_d = tap_cnt_q + TapW'(1);
          if (tap_cnt_q == TapLast) begin
            drain_cnt_d = '0;
            state_d     = StDrain;
          end
        end
      end
      StDrain: begin
        op_d = OpAcc;
        if (drain_cnt_q == DrainLast) begin
          m_result_d = DSP_P;
          m_valid_d  = 1'b1;
          state_d    = StHold;
        end else begin
          drain_cnt_d = drain_cnt_q + 3'd1;
        end
      end
      StHold: begin
        op_d = OpAcc;
        if (m_valid_q && M_READY) begin
          m_valid_d = 1'b0;
          tap_cnt_d = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Opcode skew pipe: stage 0 is registered alongside the operands.
  always_comb begin
    op_pipe_d    = op_pipe_q;
    op_pipe_d[0] = op_d;
    for (int unsigned i = 1; i <= OPMODE_SKEW; i++) begin
      op_pipe_d[i] = op_pipe_q[i-1];
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      tap_cnt_q   <= '0;
      drain_cnt_q <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_pipe_q   <= '0;
      ce_q        <= 1'b0;
      m_valid_q   <= 1'b0;
      m_result_q  <= '0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_pipe_q   <= op_pipe_d;
      ce_q        <= 1'b1;
      m_valid_q   <= m_valid_d;
      m_result_q  <= m_result_d;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer driving a behavioural DSP48A1 slice
// (A1REG=B1REG=MREG=PREG=OPMODEREG=1). Expected dot products are queued as
// frames are accepted; a monitor pops and compares as results are offered.
module tb_dsp_mac_sequencer;

  localparam int unsigned NTaps   = 4;
  localparam int unsigned PipeLat = 3;
  localparam int unsigned Skew    = 1;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        S_VALID = 1'b0;
  logic        S_READY;
  logic [17:0] S_A = '0;
  logic [17:0] S_B = '0;
  logic        M_VALID;
  logic        M_READY = 1'b1;
  logic [47:0] M_RESULT;
  logic [17:0] DSP_A;
  logic [17:0] DSP_B;
  logic [7:0]  DSP_OPMODE;
  logic        DSP_CE;
  logic [47:0] DSP_P;
  logic        BUSY;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;
  int pushed = 0;
  int popped = 0;
  logic [47:0] exp_q[$];
  longint model_sum = 0;
  int model_cnt = 0;
  bit rnd_ready = 1'b0;
  bit fixed_ready = 1'b1;
  bit mv_prev = 1'b0;
  bit hs_prev = 1'b0;

  dsp_mac_sequencer #(
    .N_TAPS(NTaps),
    .PIPE_LAT(PipeLat),
    .OPMODE_SKEW(Skew)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .S_VALID(S_VALID),
    .S_READY(S_READY),
    .S_A(S_A),
    .S_B(S_B),
    .M_VALID(M_VALID),
    .M_READY(M_READY),
    .M_RESULT(M_RESULT),
    .DSP_A(DSP_A),
    .DSP_B(DSP_B),
    .DSP_OPMODE(DSP_OPMODE),
    .DSP_CE(DSP_CE),
    .DSP_P(DSP_P),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural slice: A1/B1 -> M -> P, OPMODE registered once.
  logic signed [17:0] a1 = '0;
  logic signed [17:0] b1 = '0;
  logic signed [35:0] mreg = '0;
  logic [7:0]         opr = '0;
  logic [47:0]        p = '0;
  assign DSP_P = p;
  always @(posedge CLK) begin
    if (DSP_CE) begin
      a1   <= DSP_A;
      b1   <= DSP_B;
      mreg <= a1 * b1;
      opr  <= DSP_OPMODE;
      p    <= ((opr[1:0] == 2'b01) ? {{12{mreg[35]}}, mreg} : 48'd0) +
              ((opr[3:2] == 2'b10) ? p : 48'd0);
    end
  end

  // Downstream ready: fixed or random per cycle.
  initial forever begin
    @(posedge CLK);
    #2;
    M_READY = rnd_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result monitor / scoreboard.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (hs_prev) chk("m_valid_one_cycle", 48'(M_VALID), 48'd0);
      if (M_VALID && !mv_prev) chk("result_latency", 48'(cyc - last_acc), 48'(PipeLat + 1));
      if (M_VALID) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 48'(M_VALID), 48'd0);
        end else begin
          chk("m_result", M_RESULT, exp_q[0]);
          chk("s_ready_in_hold", 48'(S_READY), 48'd0);
          chk("busy_in_hold", 48'(BUSY), 48'd1);
          if (M_READY) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end
      hs_prev = M_VALID && M_READY;
      mv_prev = M_VALID;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dsp_a"}, 48'(DSP_A), 48'd0);
    chk({tag, "_dsp_b"}, 48'(DSP_B), 48'd0);
    chk({tag, "_opmode"}, 48'(DSP_OPMODE), 48'd0);
    chk({tag, "_ce"}, 48'(DSP_CE), 48'd0);
    chk({tag, "_s_ready"}, 48'(S_READY), 48'd0);
    chk({tag, "_m_valid"}, 48'(M_VALID), 48'd0);
    chk({tag, "_m_result"}, M_RESULT, 48'd0);
    chk({tag, "_busy"}, 48'(BUSY), 48'd0);
  endtask

  // Present one beat and hold it until accepted; update the reference sum.
  task automatic send_beat(input logic [17:0] a, input logic [17:0] b);
    bit rdy;
    int n;
    logic signed [17:0] sa;
    logic signed [17:0] sb;
    n = 0;
    S_VALID = 1'b1;
    S_A = a;
    S_B = b;
    do begin
      @(negedge CLK);
      rdy = S_READY;
      @(posedge CLK);
      #1;
      n++;
    end while (!rdy && n < 200);
    S_VALID = 1'b0;
    S_A = '0;
    S_B = '0;
    chk("accept_wait", 48'(rdy), 48'd1);
    if (rdy) begin
      sa = a;
      sb = b;
      model_sum += longint'(sa) * longint'(sb);
      model_cnt++;
      last_acc = cyc;
      if (model_cnt == NTaps) begin
        exp_q.push_back(model_sum[47:0]);
        pushed++;
        model_sum = 0;
        model_cnt = 0;
      end
    end
  endtask

  task automatic idle_busy(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk("busy_during_gap", 48'(BUSY), 48'd1);
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("drain_wait", 48'(exp_q.size()), 48'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic basic_frame();
    send_beat(18'd2, 18'd5);
    send_beat(18'd3, 18'd4);
    send_beat(18'd1, 18'd1);
    send_beat(18'd6, 18'd7);
  endtask

  initial begin
    int n;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("ce_after_reset", 48'(DSP_CE), 48'd1);
    chk("idle_not_busy", 48'(BUSY), 48'd0);
    chk("idle_ready", 48'(S_READY), 48'd1);

    // Basic back-to-back frame: expect 65.
    basic_frame();
    wait_drain();

    // Bubbles between beats.
    send_beat(18'd2, 18'd5);
    idle_busy(2);
    send_beat(18'd3, 18'd4);
    idle_busy(2);
    send_beat(18'd1, 18'd1);
    idle_busy(2);
    send_beat(18'd6, 18'd7);
    wait_drain();

    // Signed: -3*5 + 1 = -14.
    send_beat(18'h3FFFD, 18'd5);
    send_beat(18'd1, 18'd1);
    send_beat(18'd0, 18'd0);
    send_beat(18'd0, 18'd0);
    wait_drain();

    // Backpressure, then a fresh frame (1,1)x4.
    fixed_ready = 1'b0;
    basic_frame();
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!M_VALID && n < 50);
    chk("m_valid_wait", 48'(M_VALID), 48'd1);
    repeat (5) @(negedge CLK);
    chk("held_valid", 48'(M_VALID), 48'd1);
    chk("held_result", M_RESULT, 48'd65);
    fixed_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(18'd1, 18'd1);
    wait_drain();

    // Reset mid-frame.
    send_beat(18'd9, 18'd9);
    send_beat(18'd7, 18'd3);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_sum = 0;
    model_cnt = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    basic_frame();
    wait_drain();

    // Randomized frames with random gaps and random downstream ready.
    rnd_ready = 1'b1;
    for (int f = 0; f < 12; f++) begin
      for (int t = 0; t < NTaps; t++) begin
        send_beat(18'($urandom), 18'($urandom));
        if ($urandom_range(0, 2) == 0) begin
          repeat ($urandom_range(1, 3)) begin
            @(posedge CLK);
            #1;
          end
        end
      end
    end
    wait_drain();
    rnd_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    chk("results_popped", 48'(popped), 48'(pushed));
    chk("final_idle", 48'(BUSY), 48'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
